// File: rtl/riscv_trap_pkg.sv
// rtl/riscv_trap_pkg.sv - shared CSR addresses, cause codes, privilege and FSM encodings
package riscv_trap_pkg;

  localparam logic [11:0] CSR_SEPC    = 12'h141;
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  localparam logic [3:0] IRQ_MSI     = 4'd3;
  localparam logic [3:0] IRQ_MTI     = 4'd7;
  localparam logic [3:0] IRQ_MEI     = 4'd11;
  localparam logic [3:0] EXC_ILLEGAL = 4'd2;

  localparam logic [1:0] PRIV_U = 2'b00;
  localparam logic [1:0] PRIV_S = 2'b01;
  localparam logic [1:0] PRIV_M = 2'b11;

  typedef enum logic [1:0] {
    RET_NONE = 2'd0,
    RET_M    = 2'd1,
    RET_S    = 2'd2
  } ret_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_BLANK = 2'd2
  } state_e;

  // The reserved encoding 2'b10 is mapped to U so priv never holds an illegal mode.
  function automatic logic [1:0] legal_priv(input logic [1:0] p);
    return (p == 2'b10) ? PRIV_U : p;
  endfunction

endpackage

// File: rtl/riscv_trap_ctrl_if.sv
// rtl/riscv_trap_ctrl_if.sv - write-back side bus of the trap controller
interface riscv_trap_ctrl_if #(
  parameter int XLEN = 64
);
  logic            i_riscv_trap_wb_valid;
  logic [XLEN-1:0] i_riscv_trap_wb_pc;
  logic            i_riscv_trap_exc_valid;
  logic [3:0]      i_riscv_trap_exc_cause;
  logic [XLEN-1:0] i_riscv_trap_exc_tval;
  logic            i_riscv_trap_mret;
  logic            i_riscv_trap_sret;
  logic            i_riscv_trap_msip;
  logic            i_riscv_trap_mtip;
  logic            i_riscv_trap_meip;
  logic            i_riscv_trap_csr_we;
  logic [11:0]     i_riscv_trap_csr_addr;
  logic [XLEN-1:0] i_riscv_trap_csr_wdata;
  logic            i_riscv_trap_icache_stall;
  logic            o_riscv_trap_gototrap;
  logic [1:0]      o_riscv_trap_returnfromtrap;
  logic [XLEN-1:0] o_riscv_trap_csr_rdata;
  logic [XLEN-1:0] o_riscv_trap_tvec_pc;
  logic [XLEN-1:0] o_riscv_trap_mepc;
  logic [XLEN-1:0] o_riscv_trap_sepc;
  logic [1:0]      o_riscv_trap_priv;

  modport master (
    output i_riscv_trap_wb_valid, i_riscv_trap_wb_pc, i_riscv_trap_exc_valid,
           i_riscv_trap_exc_cause, i_riscv_trap_exc_tval, i_riscv_trap_mret,
           i_riscv_trap_sret, i_riscv_trap_msip, i_riscv_trap_mtip, i_riscv_trap_meip,
           i_riscv_trap_csr_we, i_riscv_trap_csr_addr, i_riscv_trap_csr_wdata,
           i_riscv_trap_icache_stall,
    input  o_riscv_trap_gototrap, o_riscv_trap_returnfromtrap, o_riscv_trap_csr_rdata,
           o_riscv_trap_tvec_pc, o_riscv_trap_mepc, o_riscv_trap_sepc, o_riscv_trap_priv
  );

  modport slave (
    input  i_riscv_trap_wb_valid, i_riscv_trap_wb_pc, i_riscv_trap_exc_valid,
           i_riscv_trap_exc_cause, i_riscv_trap_exc_tval, i_riscv_trap_mret,
           i_riscv_trap_sret, i_riscv_trap_msip, i_riscv_trap_mtip, i_riscv_trap_meip,
           i_riscv_trap_csr_we, i_riscv_trap_csr_addr, i_riscv_trap_csr_wdata,
           i_riscv_trap_icache_stall,
    output o_riscv_trap_gototrap, o_riscv_trap_returnfromtrap, o_riscv_trap_csr_rdata,
           o_riscv_trap_tvec_pc, o_riscv_trap_mepc, o_riscv_trap_sepc, o_riscv_trap_priv
  );
endinterface

// File: rtl/riscv_trap_csr.sv
// rtl/riscv_trap_csr.sv - machine trap CSR subset, privilege mode and read mux
module riscv_trap_csr
  import riscv_trap_pkg::*;
#(
  parameter int              XLEN        = 64,
  parameter logic [XLEN-1:0] RESET_MTVEC = '0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_csr_we,
  input  logic [11:0]     i_csr_addr,
  input  logic [XLEN-1:0] i_csr_wdata,
  input  logic            i_msip,
  input  logic            i_mtip,
  input  logic            i_meip,
  input  logic            i_trap_acc,
  input  logic            i_trap_irq,
  input  logic [3:0]      i_trap_cause,
  input  logic [XLEN-1:0] i_trap_epc,
  input  logic [XLEN-1:0] i_trap_tval,
  input  logic            i_mret_acc,
  input  logic            i_sret_acc,
  output logic [XLEN-1:0] o_rdata,
  output logic [XLEN-1:0] o_mtvec,
  output logic [XLEN-1:0] o_mepc,
  output logic [XLEN-1:0] o_sepc,
  output logic [2:0]      o_mie_en,
  output logic            o_mstatus_mie,
  output logic [1:0]      o_priv
);

  logic            r_sie, r_mie, r_spie, r_mpie, r_spp;
  logic [1:0]      r_mpp;
  logic [1:0]      r_priv;
  logic [2:0]      r_mie_en;
  logic [XLEN-1:0] r_mtvec, r_mepc, r_sepc, r_mcause, r_mtval;
  logic [XLEN-1:0] w_mstatus, w_mie, w_mip;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sie    <= 1'b0;
      r_mie    <= 1'b0;
      r_spie   <= 1'b0;
      r_mpie   <= 1'b0;
      r_spp    <= 1'b0;
      r_mpp    <= PRIV_U;
      r_priv   <= PRIV_M;
      r_mie_en <= '0;
      r_mtvec  <= RESET_MTVEC;
      r_mepc   <= '0;
      r_sepc   <= '0;
      r_mcause <= '0;
      r_mtval  <= '0;
    end else if (i_trap_acc) begin
      r_mepc   <= {i_trap_epc[XLEN-1:2], 2'b00};
      r_mcause <= {i_trap_irq, {(XLEN-5){1'b0}}, i_trap_cause};
      r_mtval  <= i_trap_tval;
      r_mpie   <= r_mie;
      r_mie    <= 1'b0;
      r_mpp    <= r_priv;
      r_priv   <= PRIV_M;
    end else if (i_mret_acc) begin
      r_mie  <= r_mpie;
      r_mpie <= 1'b1;
      r_priv <= r_mpp;
      r_mpp  <= PRIV_U;
    end else if (i_sret_acc) begin
      r_sie  <= r_spie;
      r_spie <= 1'b1;
      r_priv <= {1'b0, r_spp};
      r_spp  <= 1'b0;
    end else if (i_csr_we) begin
      case (i_csr_addr)
        CSR_MSTATUS: begin
          r_sie  <= i_csr_wdata[1];
          r_mie  <= i_csr_wdata[3];
          r_spie <= i_csr_wdata[5];
          r_mpie <= i_csr_wdata[7];
          r_spp  <= i_csr_wdata[8];
          r_mpp  <= legal_priv(i_csr_wdata[12:11]);
        end
        CSR_MIE:    r_mie_en <= {i_csr_wdata[11], i_csr_wdata[7], i_csr_wdata[3]};
        CSR_MTVEC:  r_mtvec  <= i_csr_wdata;
        CSR_MEPC:   r_mepc   <= {i_csr_wdata[XLEN-1:2], 2'b00};
        CSR_SEPC:   r_sepc   <= {i_csr_wdata[XLEN-1:2], 2'b00};
        CSR_MCAUSE: r_mcause <= i_csr_wdata;
        CSR_MTVAL:  r_mtval  <= i_csr_wdata;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_mstatus        = '0;
    w_mstatus[1]     = r_sie;
    w_mstatus[3]     = r_mie;
    w_mstatus[5]     = r_spie;
    w_mstatus[7]     = r_mpie;
    w_mstatus[8]     = r_spp;
    w_mstatus[12:11] = r_mpp;
    w_mie            = '0;
    w_mie[3]         = r_mie_en[0];
    w_mie[7]         = r_mie_en[1];
    w_mie[11]        = r_mie_en[2];
    w_mip            = '0;
    w_mip[3]         = i_msip;
    w_mip[7]         = i_mtip;
    w_mip[11]        = i_meip;
    case (i_csr_addr)
      CSR_MSTATUS: o_rdata = w_mstatus;
      CSR_MIE:     o_rdata = w_mie;
      CSR_MIP:     o_rdata = w_mip;
      CSR_MTVEC:   o_rdata = r_mtvec;
      CSR_MEPC:    o_rdata = r_mepc;
      CSR_SEPC:    o_rdata = r_sepc;
      CSR_MCAUSE:  o_rdata = r_mcause;
      CSR_MTVAL:   o_rdata = r_mtval;
      default:     o_rdata = '0;
    endcase
  end

  assign o_mtvec       = r_mtvec;
  assign o_mepc        = r_mepc;
  assign o_sepc        = r_sepc;
  assign o_mie_en      = r_mie_en;
  assign o_mstatus_mie = r_mie;
  assign o_priv        = r_priv;

endmodule

// File: rtl/riscv_trap_ctrl.sv
// rtl/riscv_trap_ctrl.sv - write-back trap/return arbiter with stall hold and post-event blanking
module riscv_trap_ctrl
  import riscv_trap_pkg::*;
#(
  parameter int              XLEN        = 64,
  parameter logic [XLEN-1:0] RESET_MTVEC = 64'h0
) (
  input logic               i_riscv_clk,
  input logic               i_riscv_rst,
  riscv_trap_ctrl_if.slave  bus
);

  state_e          r_state, w_next;
  logic            r_hold_trap, r_hold_irq;
  logic [3:0]      r_hold_cause;
  ret_e            r_hold_ret;
  logic [XLEN-1:0] r_hold_epc, r_hold_tval;

  logic [XLEN-1:0] w_mtvec, w_base;
  logic [2:0]      w_mie_en;
  logic            w_mstatus_mie;
  logic [1:0]      w_priv;

  logic            w_irq_en, w_irq_mei, w_irq_msi, w_irq_mti, w_irq_any;
  logic            w_bad_ret, w_exc;
  logic            w_new_trap;
  logic [3:0]      w_new_cause;
  logic [XLEN-1:0] w_new_tval;
  ret_e            w_new_ret;

  logic            w_cur_trap, w_cur_irq;
  logic [3:0]      w_cur_cause;
  ret_e            w_cur_ret;
  logic [XLEN-1:0] w_cur_epc, w_cur_tval;
  logic            w_req, w_accept, w_csr_we;

  assign w_irq_en  = bus.i_riscv_trap_wb_valid && (w_priv != PRIV_M || w_mstatus_mie);
  assign w_irq_mei = w_irq_en && w_mie_en[2] && bus.i_riscv_trap_meip;
  assign w_irq_msi = w_irq_en && w_mie_en[0] && bus.i_riscv_trap_msip;
  assign w_irq_mti = w_irq_en && w_mie_en[1] && bus.i_riscv_trap_mtip;
  assign w_irq_any = w_irq_mei || w_irq_msi || w_irq_mti;

  // Returns that are not allowed from the current mode become illegal-instruction traps.
  assign w_bad_ret = (bus.i_riscv_trap_mret && w_priv != PRIV_M) ||
                     (bus.i_riscv_trap_sret && w_priv == PRIV_U);
  assign w_exc     = bus.i_riscv_trap_wb_valid && (bus.i_riscv_trap_exc_valid || w_bad_ret);

  always_comb begin
    w_new_trap  = w_irq_any || w_exc;
    w_new_cause = w_irq_mei ? IRQ_MEI : w_irq_msi ? IRQ_MSI : w_irq_mti ? IRQ_MTI :
                  bus.i_riscv_trap_exc_valid ? bus.i_riscv_trap_exc_cause : EXC_ILLEGAL;
    w_new_tval  = (w_irq_any || !bus.i_riscv_trap_exc_valid) ? '0 : bus.i_riscv_trap_exc_tval;
    w_new_ret   = RET_NONE;
    if (!w_new_trap && bus.i_riscv_trap_wb_valid) begin
      if (bus.i_riscv_trap_mret)      w_new_ret = RET_M;
      else if (bus.i_riscv_trap_sret) w_new_ret = RET_S;
    end
  end

  always_comb begin
    w_cur_trap  = 1'b0;
    w_cur_irq   = 1'b0;
    w_cur_cause = '0;
    w_cur_ret   = RET_NONE;
    w_cur_epc   = '0;
    w_cur_tval  = '0;
    case (r_state)
      ST_IDLE: if (!i_riscv_rst) begin
        w_cur_trap  = w_new_trap;
        w_cur_irq   = w_irq_any;
        w_cur_cause = w_new_cause;
        w_cur_ret   = w_new_ret;
        w_cur_epc   = bus.i_riscv_trap_wb_pc;
        w_cur_tval  = w_new_tval;
      end
      ST_HOLD: begin
        w_cur_trap  = r_hold_trap;
        w_cur_irq   = r_hold_irq;
        w_cur_cause = r_hold_cause;
        w_cur_ret   = r_hold_ret;
        w_cur_epc   = r_hold_epc;
        w_cur_tval  = r_hold_tval;
      end
      default: ;
    endcase
  end

  assign w_req    = w_cur_trap || (w_cur_ret != RET_NONE);
  assign w_accept = w_req && !bus.i_riscv_trap_icache_stall;
  assign w_csr_we = bus.i_riscv_trap_csr_we && (r_state == ST_IDLE) && !w_req;

  always_ff @(posedge i_riscv_clk or posedge i_riscv_rst) begin
    if (i_riscv_rst) r_state <= ST_IDLE;
    else             r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_req) w_next = bus.i_riscv_trap_icache_stall ? ST_HOLD : ST_BLANK;
      ST_HOLD:  if (!bus.i_riscv_trap_icache_stall) w_next = ST_BLANK;
      ST_BLANK: w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_riscv_clk or posedge i_riscv_rst) begin
    if (i_riscv_rst) begin
      r_hold_trap  <= 1'b0;
      r_hold_irq   <= 1'b0;
      r_hold_cause <= '0;
      r_hold_ret   <= RET_NONE;
      r_hold_epc   <= '0;
      r_hold_tval  <= '0;
    end else if (r_state == ST_IDLE && w_req && bus.i_riscv_trap_icache_stall) begin
      r_hold_trap  <= w_cur_trap;
      r_hold_irq   <= w_cur_irq;
      r_hold_cause <= w_cur_cause;
      r_hold_ret   <= w_cur_ret;
      r_hold_epc   <= w_cur_epc;
      r_hold_tval  <= w_cur_tval;
    end
  end

  riscv_trap_csr #(.XLEN(XLEN), .RESET_MTVEC(RESET_MTVEC)) u_csr (
    .i_clk         (i_riscv_clk),
    .i_rst         (i_riscv_rst),
    .i_csr_we      (w_csr_we),
    .i_csr_addr    (bus.i_riscv_trap_csr_addr),
    .i_csr_wdata   (bus.i_riscv_trap_csr_wdata),
    .i_msip        (bus.i_riscv_trap_msip),
    .i_mtip        (bus.i_riscv_trap_mtip),
    .i_meip        (bus.i_riscv_trap_meip),
    .i_trap_acc    (w_accept && w_cur_trap),
    .i_trap_irq    (w_cur_irq),
    .i_trap_cause  (w_cur_cause),
    .i_trap_epc    (w_cur_epc),
    .i_trap_tval   (w_cur_tval),
    .i_mret_acc    (w_accept && w_cur_ret == RET_M),
    .i_sret_acc    (w_accept && w_cur_ret == RET_S),
    .o_rdata       (bus.o_riscv_trap_csr_rdata),
    .o_mtvec       (w_mtvec),
    .o_mepc        (bus.o_riscv_trap_mepc),
    .o_sepc        (bus.o_riscv_trap_sepc),
    .o_mie_en      (w_mie_en),
    .o_mstatus_mie (w_mstatus_mie),
    .o_priv        (w_priv)
  );

  // Vectored mode only applies to interrupts; exceptions always go to the base.
  assign w_base = {w_mtvec[XLEN-1:2], 2'b00};
  assign bus.o_riscv_trap_tvec_pc = (w_mtvec[1:0] == 2'b01 && w_cur_irq) ?
                                    w_base + {{(XLEN-6){1'b0}}, w_cur_cause, 2'b00} : w_base;

  assign bus.o_riscv_trap_gototrap       = w_cur_trap;
  assign bus.o_riscv_trap_returnfromtrap = w_cur_ret;
  assign bus.o_riscv_trap_priv           = w_priv;

endmodule

// File: tb/tb_riscv_trap_ctrl.sv
// tb/tb_riscv_trap_ctrl.sv - directed self-checking bench for riscv_trap_ctrl
module tb_riscv_trap_ctrl;
  import riscv_trap_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   n_hi;

  riscv_trap_ctrl_if #(.XLEN(64)) bus ();

  riscv_trap_ctrl #(.XLEN(64), .RESET_MTVEC(64'h0)) dut (
    .i_riscv_clk (clk),
    .i_riscv_rst (rst),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_wb();
    bus.i_riscv_trap_wb_valid     = 1'b0;
    bus.i_riscv_trap_wb_pc        = '0;
    bus.i_riscv_trap_exc_valid    = 1'b0;
    bus.i_riscv_trap_exc_cause    = '0;
    bus.i_riscv_trap_exc_tval     = '0;
    bus.i_riscv_trap_mret         = 1'b0;
    bus.i_riscv_trap_sret         = 1'b0;
    bus.i_riscv_trap_msip         = 1'b0;
    bus.i_riscv_trap_mtip         = 1'b0;
    bus.i_riscv_trap_meip         = 1'b0;
    bus.i_riscv_trap_csr_we       = 1'b0;
    bus.i_riscv_trap_icache_stall = 1'b0;
  endtask

  task automatic csr_wr(input logic [11:0] addr, input logic [63:0] data);
    bus.i_riscv_trap_csr_we    = 1'b1;
    bus.i_riscv_trap_csr_addr  = addr;
    bus.i_riscv_trap_csr_wdata = data;
    tick();
    bus.i_riscv_trap_csr_we    = 1'b0;
  endtask

  task automatic csr_rd(input string tag, input logic [11:0] addr, input logic [63:0] exp);
    bus.i_riscv_trap_csr_addr = addr;
    #1;
    chk(tag, bus.o_riscv_trap_csr_rdata, exp);
  endtask

  task automatic set_exc(input logic [63:0] pc, input logic [3:0] cause, input logic [63:0] tval);
    bus.i_riscv_trap_wb_valid  = 1'b1;
    bus.i_riscv_trap_wb_pc     = pc;
    bus.i_riscv_trap_exc_valid = 1'b1;
    bus.i_riscv_trap_exc_cause = cause;
    bus.i_riscv_trap_exc_tval  = tval;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    clear_wb();
    bus.i_riscv_trap_csr_addr  = '0;
    bus.i_riscv_trap_csr_wdata = '0;
    #12;
    chk("rst_gototrap", {63'd0, bus.o_riscv_trap_gototrap}, 64'd0);
    chk("rst_ret", {62'd0, bus.o_riscv_trap_returnfromtrap}, 64'd0);
    chk("rst_priv", {62'd0, bus.o_riscv_trap_priv}, 64'd3);
    chk("rst_mepc", bus.o_riscv_trap_mepc, 64'd0);
    chk("rst_tvec", bus.o_riscv_trap_tvec_pc, 64'd0);
    csr_rd("rst_mstatus", CSR_MSTATUS, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // exception with a concurrent CSR write that must be dropped
    csr_wr(CSR_MTVEC, 64'h200);
    csr_rd("mtvec_wr", CSR_MTVEC, 64'h200);
    set_exc(64'h100, 4'd5, 64'h80);
    bus.i_riscv_trap_csr_we    = 1'b1;
    bus.i_riscv_trap_csr_addr  = CSR_MIE;
    bus.i_riscv_trap_csr_wdata = 64'h888;
    #1;
    chk("exc_gototrap", {63'd0, bus.o_riscv_trap_gototrap}, 64'd1);
    chk("exc_tvec", bus.o_riscv_trap_tvec_pc, 64'h200);
    tick();
    bus.i_riscv_trap_csr_we = 1'b0;
    chk("exc_blank", {63'd0, bus.o_riscv_trap_gototrap}, 64'd0);
    chk("exc_mepc", bus.o_riscv_trap_mepc, 64'h100);
    chk("exc_priv", {62'd0, bus.o_riscv_trap_priv}, 64'd3);
    csr_rd("exc_mcause", CSR_MCAUSE, 64'd5);
    csr_rd("exc_mtval", CSR_MTVAL, 64'h80);
    csr_rd("exc_mie_dropped", CSR_MIE, 64'd0);
    csr_rd("exc_mstatus", CSR_MSTATUS, 64'h1800);
    clear_wb();
    tick();

    // vectored interrupt: MEI beats MTI
    csr_wr(CSR_MIE, 64'h888);
    csr_wr(CSR_MSTATUS, 64'h8);
    csr_wr(CSR_MTVEC, 64'h401);
    bus.i_riscv_trap_wb_valid = 1'b1;
    bus.i_riscv_trap_wb_pc    = 64'h300;
    bus.i_riscv_trap_mtip     = 1'b1;
    bus.i_riscv_trap_meip     = 1'b1;
    #1;
    chk("irq_gototrap", {63'd0, bus.o_riscv_trap_gototrap}, 64'd1);
    chk("irq_tvec", bus.o_riscv_trap_tvec_pc, 64'h42C);
    tick();
    csr_rd("irq_mcause", CSR_MCAUSE, 64'h8000_0000_0000_000B);
    csr_rd("irq_mtval", CSR_MTVAL, 64'd0);
    csr_rd("irq_mstatus", CSR_MSTATUS, 64'h1880);
    chk("irq_mepc", bus.o_riscv_trap_mepc, 64'h300);
    clear_wb();
    tick();

    // stalled exception held four cycles; msip and pc changes during HOLD ignored
    csr_wr(CSR_MSTATUS, 64'h8);
    n_hi = 0;
    set_exc(64'h500, 4'd4, 64'h44);
    bus.i_riscv_trap_icache_stall = 1'b1;
    #1;
    if (bus.o_riscv_trap_gototrap) n_hi++;
    chk("hold_tvec0", bus.o_riscv_trap_tvec_pc, 64'h400);
    tick();
    bus.i_riscv_trap_msip  = 1'b1;
    bus.i_riscv_trap_wb_pc = 64'h600;
    #1;
    if (bus.o_riscv_trap_gototrap) n_hi++;
    chk("hold_tvec1", bus.o_riscv_trap_tvec_pc, 64'h400);
    csr_rd("hold_mcause_old", CSR_MCAUSE, 64'h8000_0000_0000_000B);
    tick();
    if (bus.o_riscv_trap_gototrap) n_hi++;
    tick();
    bus.i_riscv_trap_icache_stall = 1'b0;
    #1;
    if (bus.o_riscv_trap_gototrap) n_hi++;
    tick();
    chk("hold_cycles", 64'(n_hi), 64'd4);
    chk("hold_blank", {63'd0, bus.o_riscv_trap_gototrap}, 64'd0);
    chk("hold_mepc", bus.o_riscv_trap_mepc, 64'h500);
    csr_rd("hold_mcause", CSR_MCAUSE, 64'd4);
    csr_rd("hold_mtval", CSR_MTVAL, 64'h44);
    clear_wb();
    tick();

    // mret to U, then illegal mret from U
    csr_wr(CSR_MSTATUS, 64'h80);
    bus.i_riscv_trap_wb_valid = 1'b1;
    bus.i_riscv_trap_wb_pc    = 64'h700;
    bus.i_riscv_trap_mret     = 1'b1;
    #1;
    chk("mret_ret", {62'd0, bus.o_riscv_trap_returnfromtrap}, 64'd1);
    chk("mret_gototrap", {63'd0, bus.o_riscv_trap_gototrap}, 64'd0);
    tick();
    chk("mret_priv", {62'd0, bus.o_riscv_trap_priv}, 64'd0);
    csr_rd("mret_mstatus", CSR_MSTATUS, 64'h88);
    clear_wb();
    tick();
    bus.i_riscv_trap_wb_valid = 1'b1;
    bus.i_riscv_trap_wb_pc    = 64'h704;
    bus.i_riscv_trap_mret     = 1'b1;
    #1;
    chk("badmret_gototrap", {63'd0, bus.o_riscv_trap_gototrap}, 64'd1);
    chk("badmret_ret", {62'd0, bus.o_riscv_trap_returnfromtrap}, 64'd0);
    tick();
    chk("badmret_priv", {62'd0, bus.o_riscv_trap_priv}, 64'd3);
    chk("badmret_mepc", bus.o_riscv_trap_mepc, 64'h704);
    csr_rd("badmret_mcause", CSR_MCAUSE, 64'd2);
    csr_rd("badmret_mtval", CSR_MTVAL, 64'd0);
    csr_rd("badmret_mstatus", CSR_MSTATUS, 64'h80);
    clear_wb();
    tick();

    // mret into S, sret into U, then illegal sret from U
    csr_wr(CSR_MSTATUS, 64'h800);
    bus.i_riscv_trap_wb_valid = 1'b1;
    bus.i_riscv_trap_mret     = 1'b1;
    tick();
    chk("to_s_priv", {62'd0, bus.o_riscv_trap_priv}, 64'd1);
    clear_wb();
    tick();
    bus.i_riscv_trap_wb_valid = 1'b1;
    bus.i_riscv_trap_sret     = 1'b1;
    #1;
    chk("sret_ret", {62'd0, bus.o_riscv_trap_returnfromtrap}, 64'd2);
    tick();
    chk("sret_priv", {62'd0, bus.o_riscv_trap_priv}, 64'd0);
    csr_rd("sret_mstatus", CSR_MSTATUS, 64'hA0);
    clear_wb();
    tick();
    bus.i_riscv_trap_wb_valid = 1'b1;
    bus.i_riscv_trap_sret     = 1'b1;
    #1;
    chk("badsret_gototrap", {63'd0, bus.o_riscv_trap_gototrap}, 64'd1);
    tick();
    csr_rd("badsret_mcause", CSR_MCAUSE, 64'd2);
    chk("badsret_priv", {62'd0, bus.o_riscv_trap_priv}, 64'd3);
    clear_wb();
    tick();

    // CSR corner cases
    csr_wr(12'h7C0, 64'hFFFF);
    csr_rd("unsupported", 12'h7C0, 64'd0);
    csr_wr(CSR_SEPC, 64'h1237);
    csr_rd("sepc_align", CSR_SEPC, 64'h1234);
    chk("sepc_out", bus.o_riscv_trap_sepc, 64'h1234);
    bus.i_riscv_trap_mtip = 1'b1;
    csr_rd("mip_mtip", CSR_MIP, 64'h80);
    bus.i_riscv_trap_mtip = 1'b0;

    // asynchronous reset while holding a stalled request
    set_exc(64'h900, 4'd6, 64'h10);
    bus.i_riscv_trap_icache_stall = 1'b1;
    tick();
    chk("prerst_hold", {63'd0, bus.o_riscv_trap_gototrap}, 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_gototrap", {63'd0, bus.o_riscv_trap_gototrap}, 64'd0);
    chk("arst_ret", {62'd0, bus.o_riscv_trap_returnfromtrap}, 64'd0);
    chk("arst_priv", {62'd0, bus.o_riscv_trap_priv}, 64'd3);
    chk("arst_mepc", bus.o_riscv_trap_mepc, 64'd0);
    chk("arst_sepc", bus.o_riscv_trap_sepc, 64'd0);
    chk("arst_tvec", bus.o_riscv_trap_tvec_pc, 64'd0);
    clear_wb();
    #1;
    rst = 1'b0;
    tick();
    chk("post_rst_idle", {63'd0, bus.o_riscv_trap_gototrap}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_trap_ctrl.md
Name: riscv_trap_ctrl

Overview:
- Machine-level trap controller at the write-back boundary. It decides whether the retiring instruction takes an exception or interrupt, or executes mret/sret.
- Drives the trap-request and return-from-trap-code inputs of the downstream trap write-back flush/PC-select stage.
- Owns the trap CSR subset and the current privilege mode.
- Holds a request stable across I-cache stalls. Blanks the flushed slot for one cycle after every accepted event.

Parameters:
- XLEN, 64, data/address width.
- RESET_MTVEC, 64'h0, mtvec reset value.

Ports:
- i_riscv_clk  in  1  core clock
- i_riscv_rst  in  1  reset, asynchronous, active-high
- i_riscv_trap_wb_valid  in  1  valid instruction retiring in WB
- i_riscv_trap_wb_pc  in  XLEN  PC of WB instruction
- i_riscv_trap_exc_valid  in  1  synchronous exception on WB instruction
- i_riscv_trap_exc_cause  in  4  exception code
- i_riscv_trap_exc_tval  in  XLEN  faulting address/instruction
- i_riscv_trap_mret  in  1  WB instruction is mret
- i_riscv_trap_sret  in  1  WB instruction is sret
- i_riscv_trap_msip / _mtip / _meip  in  1 each  interrupt lines (level, already synchronous)
- i_riscv_trap_csr_we  in  1  CSR write strobe (from WB)
- i_riscv_trap_csr_addr  in  12  CSR address
- i_riscv_trap_csr_wdata  in  XLEN  CSR write data
- i_riscv_trap_icache_stall  in  1  fetch stalled; request not accepted
- o_riscv_trap_gototrap  out  1  trap request
- o_riscv_trap_returnfromtrap  out  2  0 none, 1 mret, 2 sret
- o_riscv_trap_csr_rdata  out  XLEN  combinational read of csr_addr
- o_riscv_trap_tvec_pc  out  XLEN  trap target PC
- o_riscv_trap_mepc / o_riscv_trap_sepc  out  XLEN  return targets
- o_riscv_trap_priv  out  2  current privilege (U=00, S=01, M=11)

Behaviour:
- Reset values:
  - Request outputs are 0.
  - priv=M.
  - mstatus fields MIE, MPIE, SIE, SPIE, SPP, MPP are all 0.
  - mie, mepc, sepc, mcause and mtval are 0.
  - mtvec=RESET_MTVEC.
  - FSM is in IDLE.
  - Reset mid-HOLD discards the pending request.
- Supported CSRs:
  - mstatus: bit 1 SIE, 3 MIE, 5 SPIE, 7 MPIE, 8 SPP, 12:11 MPP.
  - mie: bits 3, 7, 11.
  - mip: read-only bits 3, 7, 11 from the lines.
  - mtvec, mepc, sepc (bit 1:0 forced 0), mcause, mtval.
  - Unsupported addresses read 0 and ignore writes.
- Interrupt eligible when wb_valid && mie[i] && line[i] && (priv!=M || MIE).
  - Priority: MEI(11) > MSI(3) > MTI(7).
  - An interrupt beats an exception, mret or sret on the same instruction.
- Illegal return:
  - mret with priv!=M is converted to an exception, cause 2.
  - sret with priv=U is converted to an exception, cause 2.
  - tval=0 for the converted exception.
- Request priority in IDLE: interrupt > exception > mret > sret.
- FSM states IDLE, HOLD, BLANK:
  - IDLE, request && stall: latch kind/cause/epc/tval, go to HOLD. Outputs asserted this cycle.
  - IDLE, request && !stall: accept at this edge, go to BLANK.
  - HOLD: outputs come from the latch; WB inputs and new interrupts are ignored. When !stall, accept and go to BLANK.
  - BLANK: all requests masked, CSR writes ignored. Go to IDLE next cycle.
- Trap accept:
  - mepc<=pc, mcause<={irq,cause}, mtval<=tval (0 for interrupts).
  - MPIE<=MIE, MIE<=0, MPP<=priv, priv<=M.
- mret accept: MIE<=MPIE, MPIE<=1, priv<=MPP, MPP<=U.
- sret accept: SIE<=SPIE, SPIE<=1, priv<={0,SPP}, SPP<=0.
- tvec_pc:
  - mtvec.base when mode(1:0)=0, or when the request is an exception.
  - mtvec.base + 4*cause when mode=1 and the request is an interrupt.
- CSR write in the same cycle as any request is dropped; the trap update wins.
- CSR write with no request takes effect at the next edge.
- Outputs are a registered-state mux: the combinational path from inputs to outputs exists in IDLE only.

Decomposition:
- Shared package riscv_trap_pkg:
  - CSR addresses.
  - Cause codes (IRQ_MSI=3, IRQ_MTI=7, IRQ_MEI=11, EXC_ILLEGAL=2).
  - Privilege encodings.
  - Return codes RET_NONE/RET_M/RET_S.
  - FSM state encodings.
- One sub-module riscv_trap_csr holds the CSR registers and the read mux. The FSM and priority logic stay in the top.

Test Plan:
- exc_valid=1, cause=5, tval=0x80, pc=0x100, no stall, mtvec=0x200 -> gototrap=1 for one cycle, tvec_pc=0x200; next cycle mepc=0x100, mcause=5, mtval=0x80, priv=M; BLANK masks exc_valid.
- MIE=1, mie=0x888, mtip=meip=1, mtvec=0x401 -> mcause=0x8000...000B, tvec_pc=0x42C, MPIE=1, MIE=0.
- Request with stall=1 for 3 cycles, msip rising mid-HOLD -> gototrap held 4 cycles, cause unchanged; CSR update only on the non-stall edge.
- From priv=M with MPP=U, mret -> returnfromtrap=1; next cycle priv=U, MIE=MPIE, MPP=U. A second mret in U -> gototrap with mcause=2.
- sret with priv=S, SPP=0 -> returnfromtrap=2, priv=U. csr_we to mie in the same cycle as the trap -> mie unchanged.
- Assert rst mid-HOLD -> all outputs 0, priv=M immediately (asynchronous).
